// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with FWFT read port
// Overflow flag and saturating framing-error counter for diagnostics.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter bit DROP_ERR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     rx_error,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [7:0]               err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr;
  logic          rd;
  logic          wr_acc;

  assign rd_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign rd_data  = mem[rp];

  assign wr     = rx_done & ~(rx_error & DROP_ERR);
  assign rd     = rd_valid & rd_ready;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_acc = wr & (~full | rd);

  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem[wp] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      err_cnt  <= 8'h00;
    end else begin
      if (wr_acc) begin
        wp <= wp + PTR_ONE;
      end
      if (rd) begin
        rp <= rp + PTR_ONE;
      end
      if (wr_acc && !rd) begin
        count <= count + CNT_ONE;
      end else if (rd && !wr_acc) begin
        count <= count - CNT_ONE;
      end
      // A lost byte outranks a clear arriving in the same cycle.
      if (wr && full && !rd) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (rx_done && rx_error && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'h01;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_error = 1'b0;
  logic       rd_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [7:0] rd_data, rd_data0;
  logic       rd_valid, rd_valid0;
  logic [4:0] count, count0;
  logic       full, full0;
  logic       overflow, overflow0;
  logic [7:0] err_cnt, err_cnt0;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .DROP_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count),
    .full(full), .overflow(overflow), .ovf_clr(ovf_clr), .err_cnt(err_cnt)
  );

  uart_rx_fifo #(.DEPTH(16), .DROP_ERR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready), .count(count0),
    .full(full0), .overflow(overflow0), .ovf_clr(ovf_clr), .err_cnt(err_cnt0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, done, err;
    logic [7:0] data;
    logic       rdy, clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_cnt;
    logic       e_full, e_ovf;
    logic [7:0] e_err;
    logic [4:0] e0_cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic e, input logic [7:0] b,
                      input logic rr, input logic c);
    @(negedge clk);
    rst = r; rx_done = d; rx_error = e; rx_data = b; rd_ready = rr; ovf_clr = c;
    @(posedge clk);
    #1;
    rx_done = 1'b0; rx_error = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0; rst = 1'b1;
  endtask

  task automatic do_reset();
    step('0, '0, '0, 8'h00, '0, '0);
  endtask

  initial begin
    tbl[0]  = '{'0, '0, '0, 8'h00, '0, '0, '0, 8'h00, 5'd0, '0, '0, 8'd0, 5'd0};
    tbl[1]  = '{'1, '0, '0, 8'h00, '0, '0, '0, 8'h00, 5'd0, '0, '0, 8'd0, 5'd0};
    tbl[2]  = '{'1, '1, '0, 8'h8A, '0, '0, '1, 8'h8A, 5'd1, '0, '0, 8'd0, 5'd1};
    tbl[3]  = '{'1, '0, '0, 8'h00, '0, '0, '1, 8'h8A, 5'd1, '0, '0, 8'd0, 5'd1};
    tbl[4]  = '{'1, '0, '0, 8'h00, '1, '0, '0, 8'h00, 5'd0, '0, '0, 8'd0, 5'd0};
    tbl[5]  = '{'1, '0, '0, 8'h00, '1, '0, '0, 8'h00, 5'd0, '0, '0, 8'd0, 5'd0};
    tbl[6]  = '{'1, '1, '1, 8'hFF, '0, '0, '0, 8'h00, 5'd0, '0, '0, 8'd1, 5'd1};
    tbl[7]  = '{'1, '0, '1, 8'h11, '0, '0, '0, 8'h00, 5'd0, '0, '0, 8'd1, 5'd1};
    tbl[8]  = '{'1, '1, '0, 8'h21, '0, '0, '1, 8'h21, 5'd1, '0, '0, 8'd1, 5'd2};
    tbl[9]  = '{'1, '1, '0, 8'h22, '1, '0, '1, 8'h22, 5'd1, '0, '0, 8'd1, 5'd2};
    tbl[10] = '{'1, '0, '0, 8'h00, '1, '0, '0, 8'h00, 5'd0, '0, '0, 8'd1, 5'd1};
    tbl[11] = '{'1, '0, '0, 8'h00, '0, '1, '0, 8'h00, 5'd0, '0, '0, 8'd1, 5'd1};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst_n, tbl[i].done, tbl[i].err, tbl[i].data, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d count_keep", i), 32'(count0), 32'(tbl[i].e0_cnt));
    end

    // Fill, overflow, in-order drain, clear
    do_reset();
    for (int i = 0; i < 16; i++) step('1, '1, '0, 8'(i), '0, '0);
    chk("fill count", 32'(count), 32'd16);
    chk("fill full", 32'(full), 32'd1);
    chk("fill overflow", 32'(overflow), 32'd0);
    step('1, '1, '0, 8'hAA, '0, '0);
    chk("ovf count", 32'(count), 32'd16);
    chk("ovf flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d data", i), 32'(rd_data), 32'(i));
      step('1, '0, '0, 8'h00, '1, '0);
    end
    chk("drain empty", 32'(rd_valid), 32'd0);
    chk("drain count", 32'(count), 32'd0);
    chk("ovf sticky", 32'(overflow), 32'd1);
    step('1, '0, '0, 8'h00, '0, '1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Set beats clear; then full with simultaneous read and write
    for (int i = 0; i < 16; i++) step('1, '1, '0, 8'(i), '0, '0);
    step('1, '1, '0, 8'hAB, '0, '1);
    chk("ovf set over clr", 32'(overflow), 32'd1);
    step('1, '0, '0, 8'h00, '0, '1);
    chk("ovf cleared", 32'(overflow), 32'd0);
    step('1, '1, '0, 8'h55, '1, '0);
    chk("rw full overflow", 32'(overflow), 32'd0);
    chk("rw full count", 32'(count), 32'd16);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("rw drain%0d", i), 32'(rd_data), 32'(i));
      step('1, '0, '0, 8'h00, '1, '0);
    end
    chk("rw last byte", 32'(rd_data), 32'h55);
    step('1, '0, '0, 8'h00, '1, '0);
    chk("rw empty", 32'(rd_valid), 32'd0);

    // Error byte kept when DROP_ERR = 0, counter saturation
    do_reset();
    step('1, '1, '1, 8'hFF, '0, '0);
    chk("drop count", 32'(count), 32'd0);
    chk("drop err_cnt", 32'(err_cnt), 32'd1);
    chk("keep valid", 32'(rd_valid0), 32'd1);
    chk("keep data", 32'(rd_data0), 32'hFF);
    chk("keep err_cnt", 32'(err_cnt0), 32'd1);
    for (int i = 0; i < 253; i++) step('1, '1, '1, 8'h00, '0, '0);
    chk("err_cnt 254", 32'(err_cnt), 32'hFE);
    for (int i = 0; i < 6; i++) step('1, '1, '1, 8'h00, '0, '0);
    chk("err_cnt sat", 32'(err_cnt), 32'hFF);
    chk("err_cnt sat keep", 32'(err_cnt0), 32'hFF);

    // Pointer wrap: 40 bytes interleaved, occupancy stays small
    do_reset();
    begin
      int n_wr = 0, n_rd = 0, mcnt = 0, cyc = 0;
      logic dw, dr;
      while (n_rd < 40 && cyc < 200) begin
        dw = (n_wr < 40) && ((cyc % 3) != 2);
        dr = (mcnt > 0) && ((mcnt >= 2) || ((cyc % 2) == 0) || (n_wr == 40));
        if (dr) begin
          chk($sformatf("wrap rd%0d", n_rd), 32'(rd_data), 32'(8'h10 + n_rd));
          n_rd++;
        end
        step('1, dw, '0, 8'(8'h10 + n_wr), dr, '0);
        if (dw) n_wr++;
        mcnt = mcnt + (dw ? 1 : 0) - (dr ? 1 : 0);
        chk($sformatf("wrap cnt%0d", cyc), 32'(count), 32'(mcnt));
        if (mcnt > 3) chk("wrap occupancy", 32'(mcnt), 32'd3);
        cyc++;
      end
      chk("wrap all read", 32'(n_rd), 32'd40);
      chk("wrap overflow", 32'(overflow), 32'd0);
      chk("wrap empty", 32'(rd_valid), 32'd0);
    end

    // Reset mid-stream, with an rx_done on the reset edge
    do_reset();
    step('1, '1, '1, 8'h77, '0, '0);
    for (int i = 0; i < 5; i++) step('1, '1, '0, 8'(8'h60 + i), '0, '0);
    chk("pre-reset count", 32'(count), 32'd5);
    step('0, '1, '0, 8'h99, '0, '0);
    chk("mid reset count", 32'(count), 32'd0);
    chk("mid reset valid", 32'(rd_valid), 32'd0);
    chk("mid reset err_cnt", 32'(err_cnt), 32'd0);
    step('1, '1, '0, 8'h3C, '0, '0);
    chk("post reset valid", 32'(rd_valid), 32'd1);
    chk("post reset data", 32'(rd_data), 32'h3C);
    chk("post reset count", 32'(count), 32'd1);
    step('1, '0, '0, 8'h00, '1, '0);
    chk("post reset drained", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver: captures each byte the receiver reports as complete, discards or keeps framing-error bytes per parameter, and presents the stored bytes to the consumer over a first-word-fall-through valid/ready port. It decouples the bit-rate-paced receiver from a consumer that may stall. It also keeps a sticky overflow flag and a saturating framing-error counter for diagnostics.

## Interface
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- DROP_ERR, 1, 1 = bytes flagged with rx_error are not stored; 0 = stored like good bytes
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low (rst = 0 resets on the next clk edge)
- rx_data  input  8  byte from the receiver, valid only in the cycle rx_done = 1
- rx_done  input  1  one-cycle pulse: receiver has completed a byte
- rx_error  input  1  qualifies rx_done: framing error on this byte; ignored when rx_done = 0
- rd_data  output  8  head-of-FIFO byte, valid while rd_valid = 1
- rd_valid  output  1  FIFO not empty
- rd_ready  input  1  consumer accepts rd_data this cycle when rd_valid = 1
- count  output  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a good byte arrived while full and was lost
- ovf_clr  input  1  clears overflow on the next edge
- err_cnt  output  8  framing errors seen, saturates at 8'hFF

## Operation
- Storage: DEPTH×8 register array; write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH naturally.
- Write qualifier wr = rx_done & ~(rx_error & DROP_ERR).
- Read event rd = rd_valid & rd_ready; advances rp, decrements count.
- Write accepted when wr & (~full | rd); stores rx_data at wp, advances wp, increments count.
- Write while full with no read in the same cycle: byte dropped, overflow set to 1, pointers and count unchanged.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
- Write into empty FIFO: no bypass; rd_valid rises the cycle after the write edge.
- rd_valid = (count != 0); rd_data = mem[rp] (combinational read of head entry, FWFT).
- rd_ready while rd_valid = 0: no effect; count never underflows.
- err_cnt increments on every rx_done & rx_error, independent of DROP_ERR and of full; holds at 8'hFF.
- overflow: set has priority over ovf_clr when both occur in the same cycle.
- rx_error with rx_done = 0: ignored entirely.

## Timing
- Reset (rst = 0 at an edge): count = 0, wp = rp = 0, rd_valid = 0, full = 0, overflow = 0, err_cnt = 0; rd_data don't-care while rd_valid = 0. Array contents not reset.
- Reset mid-operation: all stored bytes discarded; an rx_done coinciding with the reset edge is ignored.
- Latency rx_done → rd_valid: 1 cycle (edge that samples rx_done updates count; rd_valid high from that edge on).
- Read throughput: one byte per cycle while rd_valid & rd_ready held high.
- rd_data changes only on an edge where rd occurs or a write lands in an empty FIFO.
- full, count, overflow, err_cnt are registered or derived purely from registered state; no combinational path from rx_* or rd_ready to any output except none (rd_data/rd_valid depend only on state).

## Test plan
- Reset then single byte: rx_data = 8'h8A, rx_done pulse, rd_ready = 0 -> next cycle rd_valid = 1, rd_data = 8'h8A, count = 1; rd_ready one cycle -> rd_valid = 0, count = 0.
- Fill and overflow (DEPTH = 16): write 8'h00..8'h0F, then 8'hAA with rd_ready = 0 -> full = 1, overflow = 1, count = 16; drain reads 8'h00..8'h0F in order, 8'hAA never appears; ovf_clr -> overflow = 0.
- Full with simultaneous read and write: FIFO full, rx_done with 8'h55 and rd_ready same cycle -> overflow stays 0, count stays 16, 8'h55 read out last.
- Framing error, DROP_ERR = 1: rx_done with rx_error, data 8'hFF -> count unchanged, err_cnt = 1; with DROP_ERR = 0 -> 8'hFF stored, err_cnt = 1.
- Pointer wrap: 40 bytes 8'h10..8'h37 written and read interleaved, count kept ≤ 3 -> output sequence exact, no loss, overflow = 0.
- Reset mid-stream: 5 bytes stored, rst = 0 one cycle -> count = 0, rd_valid = 0, err_cnt = 0; next byte 8'h3C appears alone at head.
